// File: rtl/signed_decimal_display_seq.sv
// signed_decimal_display_seq
//   Iterative signed/unsigned binary to BCD converter (shift-add-3) with
//   held seven-segment outputs, leading-zero blanking and overflow flag.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; held outputs stable
//   SHIFT | one add-3/shift step per cycle, WIDTH cycles
//   DONE  | publish working BCD/sign/overflow to held registers, pulse done
//
//   Ports:
//     clk            rising-edge clock
//     rst            asynchronous active-low reset
//     start          conversion request, sampled only in IDLE
//     val            value to convert, captured on the accepting edge
//     busy           conversion in progress
//     done           one-cycle pulse when held outputs update
//     overflow       magnitude exceeded 10^DIGITS-1 on last conversion
//     bcd            held BCD digits, digit 0 in [3:0]
//     seg7_neg_sign  minus-sign pattern (active-low segments)
//     seg7_digits    digit patterns, digit 0 in [6:0]

module seven_segment (
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);
   // active-low, bit order {g,f,e,d,c,b,a}
   always_comb begin
      seg_o = 7'h7F;
      case (bcd_i)
         4'd0: seg_o = 7'h40;
         4'd1: seg_o = 7'h79;
         4'd2: seg_o = 7'h24;
         4'd3: seg_o = 7'h30;
         4'd4: seg_o = 7'h19;
         4'd5: seg_o = 7'h12;
         4'd6: seg_o = 7'h02;
         4'd7: seg_o = 7'h78;
         4'd8: seg_o = 7'h00;
         4'd9: seg_o = 7'h10;
         default: seg_o = 7'h7F;
      endcase
   end
endmodule

module seven_segment_negative (
   input  logic       neg_i,
   output logic [6:0] seg_o
);
   // only segment g lit for a minus sign
   assign seg_o = neg_i ? 7'h3F : 7'h7F;
endmodule

module signed_decimal_display_seq #(
   parameter int WIDTH         = 8,
   parameter int DIGITS        = 3,
   parameter bit SIGNED        = 1'b1,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      val,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [6:0]            seg7_neg_sign,
   output logic [7*DIGITS-1:0]   seg7_digits
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [WIDTH-1:0] mag_q, mag_d, mag_load;
   logic [BW-1:0]   work_q, work_adj, work_d;
   logic            sign_work_q, ovf_work_q;
   logic [BW-1:0]   bcd_q;
   logic            sign_q, ovf_q, busy_q, done_q;
   logic            neg_in, top_out;

   // two's-complement negate; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned
   assign neg_in   = SIGNED && val[WIDTH-1];
   assign mag_load = neg_in ? (~val + WIDTH'(1)) : val;

   always_comb begin
      work_adj = work_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (work_q[4*i +: 4] >= 4'd5)
            work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
      // the bit leaving the top digit is lost magnitude -> overflow
      top_out = work_adj[BW-1];
      work_d  = {work_adj[BW-2:0], mag_q[WIDTH-1]};
      mag_d   = {mag_q[WIDTH-2:0], 1'b0};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mag_q       <= '0;
         work_q      <= '0;
         sign_work_q <= 1'b0;
         ovf_work_q  <= 1'b0;
         bcd_q       <= '0;
         sign_q      <= 1'b0;
         ovf_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  sign_work_q <= neg_in;
                  mag_q       <= mag_load;
                  work_q      <= '0;
                  ovf_work_q  <= 1'b0;
                  cnt_q       <= CW'(WIDTH);
                  busy_q      <= 1'b1;
                  state_q     <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               work_q     <= work_d;
               mag_q      <= mag_d;
               ovf_work_q <= ovf_work_q | top_out;
               cnt_q      <= cnt_q - CW'(1);
               if (cnt_q == CW'(1))
                  state_q <= S_DONE;
            end
            S_DONE: begin
               bcd_q   <= work_q;
               sign_q  <= sign_work_q;
               ovf_q   <= ovf_work_q;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;
   assign bcd      = bcd_q;

   // digit i blanks when it and every digit above it are zero; ones never blanks
   logic [DIGITS-1:0] blank;
   logic              hi_zero;
   always_comb begin
      hi_zero = 1'b1;
      blank   = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         hi_zero  = hi_zero & (bcd_q[4*i +: 4] == 4'd0);
         blank[i] = BLANK_LEADING && hi_zero && (i != 0);
      end
   end

   logic [7*DIGITS-1:0] seg_raw;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      seven_segment u_seg (
         .bcd_i (bcd_q[4*g +: 4]),
         .seg_o (seg_raw[7*g +: 7])
      );
      assign seg7_digits[7*g +: 7] = blank[g] ? 7'h7F : seg_raw[7*g +: 7];
   end

   seven_segment_negative u_neg (
      .neg_i (sign_q),
      .seg_o (seg7_neg_sign)
   );

endmodule

// File: doc/signed_decimal_display_seq.md
# signed_decimal_display_seq

Sequential, parametrised signed-binary to multi-digit decimal converter with seven-segment outputs. It sits between datapath registers (credit, bet, winnings) and the board's seven-segment displays. It replaces the combinational divide/modulo approach with an iterative shift-add-3 (double-dabble) engine, so width and digit count scale without wide dividers. It adds a start/busy/done handshake, registered display hold, leading-zero blanking and overflow flagging.

## Interface
- WIDTH, 8, input value width in bits (>= 2).
- DIGITS, 3, number of decimal digits displayed (>= 1).
- SIGNED, 1, 1: val is two's complement; 0: val is unsigned.
- BLANK_LEADING, 1, 1: leading zero digits blanked; 0: shown as "0".
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request conversion of val; sampled only in IDLE.
- val  input  WIDTH  value to convert; captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new results are presented.
- overflow  output  1  magnitude exceeded 10^DIGITS-1 on the last conversion.
- bcd  output  4*DIGITS  held BCD digits, digit 0 (ones) in bits [3:0].
- seg7_neg_sign  output  7  minus-sign segment pattern (seven_segment_negative).
- seg7_digits  output  7*DIGITS  segment patterns, digit 0 in bits [6:0].

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, start=1: capture sign (val[WIDTH-1] when SIGNED=1, else 0). Load the magnitude into a WIDTH-bit shift register: -val if negative, else val. The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) unsigned; no loss. Clear the BCD working register and the overflow accumulator. Set the counter to WIDTH. Go to SHIFT.
- SHIFT, each cycle: add 3 to every working digit >= 5, then shift {bcd, mag} left by 1 and decrement the counter. A 1 shifted out of the top digit sets the sticky overflow accumulator. When the counter reaches 0 after the shift, go to DONE.
- DONE: copy the working BCD, sign and overflow into the held output registers. Pulse done. Return to IDLE.
- Held outputs change only on the DONE->IDLE edge. Displays never show intermediate values.
- Negative zero is impossible: the sign register is 0 when the magnitude is 0.
- Blanking with BLANK_LEADING=1: digit i is blanked when all digits i..DIGITS-1 are 0 and i > 0. Digit 0 is never blanked.
- Blank pattern is 7'h7F (segments active-low, all off). The bcd output still carries zeros for blanked digits.
- Segment encoding uses the existing seven_segment per digit and seven_segment_negative for the sign, driven from the held registers.
- Results are undefined only when WIDTH is out of range. An insufficient DIGITS setting is legal: the low digits are shown and overflow=1.

## Timing
- Reset (asynchronous assert, rst=0) drives all of the following: state IDLE; busy=0; done=0; overflow=0; bcd=0; sign=0.
- Reset display values: seg7_neg_sign = the "off" pattern; digit 0 shows "0"; higher digits show 7'h7F (BLANK_LEADING=1) or "0".
- Reset asserted mid-conversion aborts it. The held outputs return to reset values; there is no partial update.
- Start accepted at edge E0: busy=1 from E0 to E_(WIDTH+1).
- SHIFT occupies edges E1..E_WIDTH. DONE occupies the cycle after E_WIDTH.
- At E_(WIDTH+1): outputs update, done=1 for exactly one cycle, and busy=0.
- Latency from the accepting edge to done is WIDTH+1 edges; throughput is one conversion per WIDTH+2 cycles.
- start while busy=1 is ignored and not queued.
- start high during the done cycle (state IDLE) is accepted, so back-to-back conversions run with no gap.
- start held high continuously causes a conversion to restart every WIDTH+2 cycles.

## Test plan
- WIDTH=8, DIGITS=3, SIGNED=1, val=8'h7F, start at E0. Required: done high only after E9; bcd=12'h127; neg sign off; busy high E0..E9.
- val=8'h80. Required: bcd=12'h128; seg7_neg_sign shows minus; overflow=0.
- val=8'hF6 (-10). Required: bcd=12'h010; hundreds=7'h7F; tens="1"; ones="0"; minus shown. With BLANK_LEADING=0, hundreds="0".
- val=0 after a negative result. Required: minus off; digits 2 and 1 blank; ones="0".
- Handshake: start pulse at E3 while busy is ignored, and the held outputs stay unchanged. Then start high in the done cycle with val=8'd5: accepted; second done comes 9 edges later with bcd=12'h005.
- Reset and overflow:
  - rst=0 asserted mid-SHIFT at E5 clears all outputs immediately; a following start converts correctly.
  - SIGNED=0, DIGITS=2, val=8'd100: overflow=1, bcd=8'h00.
  - SIGNED=0, DIGITS=2, val=8'd99: overflow=0, bcd=8'h99.
